// File: rtl/robot_pkg.sv
// Shared types for the robot behaviour controller: top-level mode, camera
// follow sub-state and the drive command handed to the motor/PWM block.
package robot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IR   = 2'd1,
    CAM  = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    FOLLOW = 2'd1,
    PAUSE  = 2'd3
  } cam_state_t;

  typedef enum logic [2:0] {
    STOP   = 3'd0,
    LEFT   = 3'd1,
    RIGHT  = 3'd2,
    SLOW   = 3'd3,
    MEDIUM = 3'd4,
    FAST   = 3'd5
  } drive_t;

endpackage

// File: rtl/ir_debounce.sv
// Single-channel level debouncer: the accepted level follows the raw input
// only after it has disagreed with the accepted level for DEBOUNCE
// consecutive samples; any return to the accepted level restarts the count.
module ir_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db
);

  localparam int CNT_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q,  db_d;

  // Count disagreeing samples; flip the accepted level on the last one.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (raw != db_q) begin
      if (cnt_q >= CNT_LAST) begin
        db_d  = raw;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/robot_behaviour_fsm.sv
// Robot behaviour controller: arbitrates IDLE / IR obstacle avoidance /
// camera target following and registers one drive command per cycle.
module robot_behaviour_fsm
  import robot_pkg::*;
#(
  parameter int NUM_IR       = 3,
  parameter int DEBOUNCE     = 4,
  parameter int X_W          = 10,
  parameter int FRAME_W      = 640,
  parameter int CENTER_BAND  = 80,
  parameter int AREA_W       = 16,
  parameter int FAR_AREA     = 1000,
  parameter int MID_AREA     = 4000,
  parameter int NEAR_AREA    = 12000,
  parameter int LOST_TIMEOUT = 50_000_000,
  parameter int PAUSE_CYCLES = 25_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NUM_IR-1:0] ir_raw,
  input  logic              cam_valid,
  input  logic              cam_found,
  input  logic [X_W-1:0]    cam_x,
  input  logic [AREA_W-1:0] cam_area,
  output mode_t             mode,
  output cam_state_t        cam_state,
  output drive_t            drive_cmd,
  output logic              drive_change
);

  localparam int LOST_W  = $clog2(LOST_TIMEOUT + 1);
  localparam int PAUSE_W = $clog2(PAUSE_CYCLES + 1);

  // Band edges are centred-inclusive: x equal to an edge counts as centred.
  localparam logic [X_W-1:0]    X_LO   = X_W'(FRAME_W / 2 - CENTER_BAND / 2);
  localparam logic [X_W-1:0]    X_HI   = X_W'(FRAME_W / 2 + CENTER_BAND / 2);
  localparam logic [AREA_W-1:0] FAR_A  = AREA_W'(FAR_AREA);
  localparam logic [AREA_W-1:0] MID_A  = AREA_W'(MID_AREA);
  localparam logic [AREA_W-1:0] NEAR_A = AREA_W'(NEAR_AREA);

  localparam logic [LOST_W-1:0]  LOST_LAST  = LOST_W'(LOST_TIMEOUT - 1);
  localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_CYCLES - 1);

  mode_t             mode_q,   mode_d;
  cam_state_t        cam_q,    cam_d;
  drive_t            drive_q,  drive_d;
  logic              change_q, change_d;
  logic [LOST_W-1:0] lost_q,   lost_d;
  logic [PAUSE_W-1:0] pause_q, pause_d;
  logic              seen_q,   seen_d;

  logic [NUM_IR-1:0] ir_db;
  logic              ir_left, ir_right;
  drive_t            ir_drive;
  logic              found;
  logic              centred;
  logic              near;

  // Steering/speed decision for a found sample (near-range handled separately).
  function automatic drive_t follow_drive(input logic [X_W-1:0] x,
                                          input logic [AREA_W-1:0] area);
    if (x < X_LO)           return LEFT;
    else if (x > X_HI)      return RIGHT;
    else if (area >= NEAR_A) return STOP;
    else if (area >= MID_A)  return SLOW;
    else if (area >= FAR_A)  return MEDIUM;
    else                     return FAST;
  endfunction

  for (genvar g = 0; g < NUM_IR; g++) begin : g_db
    ir_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (ir_raw[g]),
      .db   (ir_db[g])
    );
  end

  assign found   = cam_valid & cam_found;
  assign centred = (cam_x >= X_LO) && (cam_x <= X_HI);
  assign near    = centred && (cam_area >= NEAR_A);

  // Fold debounced channels into left/right halves; an odd middle channel feeds both.
  always_comb begin
    ir_left  = 1'b0;
    ir_right = 1'b0;
    for (int i = 0; i < NUM_IR; i++) begin
      if (i < NUM_IR / 2)        ir_left  = ir_left  | ir_db[i];
      if (i >= (NUM_IR + 1) / 2) ir_right = ir_right | ir_db[i];
      if ((NUM_IR % 2 == 1) && (i == NUM_IR / 2)) begin
        ir_left  = ir_left  | ir_db[i];
        ir_right = ir_right | ir_db[i];
      end
    end
    if (ir_left && !ir_right)      ir_drive = RIGHT;
    else if (ir_right && !ir_left) ir_drive = LEFT;
    else                           ir_drive = STOP;
  end

  // Mode arbitration plus camera sub-FSM next state and drive command.
  always_comb begin
    mode_d  = mode_q;
    cam_d   = cam_q;
    drive_d = drive_q;
    lost_d  = lost_q;
    pause_d = pause_q;
    seen_d  = seen_q;
    if (!enable) begin
      mode_d  = IDLE;
      cam_d   = SEARCH;
      drive_d = STOP;
      lost_d  = '0;
      pause_d = '0;
      seen_d  = 1'b0;
    end else if (|ir_db) begin
      // Any camera sample arriving now is discarded.
      mode_d  = IR;
      cam_d   = SEARCH;
      drive_d = ir_drive;
      lost_d  = '0;
      pause_d = '0;
      seen_d  = 1'b0;
    end else begin
      mode_d = CAM;
      case (cam_q)
        SEARCH, FOLLOW: begin
          if (found) begin
            lost_d = '0;
            if (near) begin
              cam_d   = PAUSE;
              drive_d = STOP;
              pause_d = '0;
              seen_d  = 1'b0;
            end else begin
              cam_d   = FOLLOW;
              drive_d = follow_drive(cam_x, cam_area);
            end
          end else if (cam_q == SEARCH) begin
            drive_d = LEFT;
          end else if (lost_q >= LOST_LAST) begin
            cam_d   = SEARCH;
            drive_d = LEFT;
            lost_d  = '0;
          end else begin
            lost_d = lost_q + 1'b1;
          end
        end
        PAUSE: begin
          drive_d = STOP;
          if (pause_q >= PAUSE_LAST) begin
            pause_d = '0;
            seen_d  = 1'b0;
            lost_d  = '0;
            if (seen_q || found) begin
              cam_d = FOLLOW;
            end else begin
              cam_d   = SEARCH;
              drive_d = LEFT;
            end
          end else begin
            pause_d = pause_q + 1'b1;
            seen_d  = seen_q | found;
          end
        end
        default: begin
          cam_d   = SEARCH;
          drive_d = LEFT;
        end
      endcase
    end
    change_d = (drive_d != drive_q);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= IDLE;
      cam_q    <= SEARCH;
      drive_q  <= STOP;
      change_q <= 1'b0;
      lost_q   <= '0;
      pause_q  <= '0;
      seen_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      cam_q    <= cam_d;
      drive_q  <= drive_d;
      change_q <= change_d;
      lost_q   <= lost_d;
      pause_q  <= pause_d;
      seen_q   <= seen_d;
    end
  end

  assign mode         = mode_q;
  assign cam_state    = cam_q;
  assign drive_cmd    = drive_q;
  assign drive_change = change_q;

endmodule

// File: tb/tb_robot_behaviour_fsm.sv
// Bench for robot_behaviour_fsm: directed stimulus, a timestamp-based
// reference model checked every cycle, and hand-computed literal checks.
module tb_robot_behaviour_fsm;
  import robot_pkg::*;

  localparam int NIR     = 3;
  localparam int DEB     = 4;
  localparam int LOST    = 20;
  localparam int PAUSE_N = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  ir_raw = '0;
  logic        cam_valid = 1'b0;
  logic        cam_found = 1'b0;
  logic [9:0]  cam_x = '0;
  logic [15:0] cam_area = '0;
  mode_t       mode;
  cam_state_t  cam_state;
  drive_t      drive_cmd;
  logic        drive_change;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;
  bit count_on = 1'b0;
  int pulses = 0;

  robot_behaviour_fsm #(
    .NUM_IR(NIR), .DEBOUNCE(DEB), .X_W(10), .FRAME_W(640), .CENTER_BAND(80),
    .AREA_W(16), .FAR_AREA(1000), .MID_AREA(4000), .NEAR_AREA(12000),
    .LOST_TIMEOUT(LOST), .PAUSE_CYCLES(PAUSE_N)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ir_raw(ir_raw),
    .cam_valid(cam_valid), .cam_found(cam_found), .cam_x(cam_x), .cam_area(cam_area),
    .mode(mode), .cam_state(cam_state), .drive_cmd(drive_cmd), .drive_change(drive_change)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: 0/1/2 modes, 0/1/3 cam states, 0..5 drive codes.
  int m_mode, m_cam, m_drv, m_chg;
  int hist [NIR];
  bit db [NIR];
  int cyc, last_found, pause_start;
  bit seen;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_cam = 0; m_drv = 0; m_chg = 0;
      for (int i = 0; i < NIR; i++) begin hist[i] = 0; db[i] = 1'b0; end
      cyc = 0; last_found = 0; pause_start = 0; seen = 1'b0;
    end else begin
      int nd;
      bit any, l, r, f;
      int xi, ai;
      cyc++;
      any = 0; l = 0; r = 0;
      for (int i = 0; i < NIR; i++) begin
        if (db[i]) begin
          any = 1;
          if (2 * i + 1 <= NIR) l = 1;
          if (2 * i + 1 >= NIR) r = 1;
        end
      end
      nd = m_drv;
      xi = int'(cam_x);
      ai = int'(cam_area);
      f  = cam_valid && cam_found;
      if (!enable) begin
        m_mode = 0; m_cam = 0; nd = 0;
      end else if (any) begin
        m_mode = 1; m_cam = 0;
        nd = (l && r) ? 0 : (l ? 2 : 1);
      end else begin
        m_mode = 2;
        if (m_cam == 3) begin
          nd = 0;
          if (f) seen = 1;
          if (cyc - pause_start == PAUSE_N) begin
            if (seen) begin m_cam = 1; last_found = cyc; end
            else begin m_cam = 0; nd = 1; end
          end
        end else if (f) begin
          last_found = cyc;
          m_cam = 1;
          if (xi < 280) nd = 1;
          else if (xi > 360) nd = 2;
          else if (ai >= 12000) begin m_cam = 3; nd = 0; pause_start = cyc; seen = 0; end
          else if (ai >= 4000) nd = 3;
          else if (ai >= 1000) nd = 4;
          else nd = 5;
        end else if (m_cam == 0) begin
          nd = 1;
        end else if (cyc - last_found == LOST) begin
          m_cam = 0; nd = 1;
        end
      end
      m_chg = (nd != m_drv) ? 1 : 0;
      m_drv = nd;
      for (int i = 0; i < NIR; i++) begin
        hist[i] = ((hist[i] << 1) | int'(ir_raw[i])) & ((1 << DEB) - 1);
        if (hist[i] == (1 << DEB) - 1) db[i] = 1'b1;
        if (hist[i] == 0) db[i] = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("model_mode", 32'(mode), 32'(m_mode));
      chk("model_cam", 32'(cam_state), 32'(m_cam));
      chk("model_drive", 32'(drive_cmd), 32'(m_drv));
      chk("model_change", 32'(drive_change), 32'(m_chg));
    end
  end

  always @(negedge clk) if (count_on && drive_change) pulses++;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sample(input bit fnd, input int x, input int area);
    cam_valid = 1'b1; cam_found = fnd; cam_x = 10'(x); cam_area = 16'(area);
    @(negedge clk);
    cam_valid = 1'b0; cam_found = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    step(2);
    chk("reset_mode", 32'(mode), 32'(IDLE));
    chk("reset_cam", 32'(cam_state), 32'(SEARCH));
    chk("reset_drive", 32'(drive_cmd), 32'(STOP));
    chk("reset_change", 32'(drive_change), 0);
    rst_n = 1'b1; enable = 1'b1; chk_on = 1'b1;
    step(1);
    chk("cam_entry_mode", 32'(mode), 32'(CAM));
    chk("cam_entry_drive", 32'(drive_cmd), 32'(LEFT));

    // Reset in the middle of FOLLOW/FAST.
    sample(1, 320, 500);
    chk("follow_fast_cam", 32'(cam_state), 32'(FOLLOW));
    chk("follow_fast_drive", 32'(drive_cmd), 32'(FAST));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mode", 32'(mode), 32'(IDLE));
    chk("async_rst_cam", 32'(cam_state), 32'(SEARCH));
    chk("async_rst_drive", 32'(drive_cmd), 32'(STOP));
    step(1);
    rst_n = 1'b1;
    step(1);

    // Debounce and IR steering.
    ir_raw = 3'b001; step(3); ir_raw = 3'b000; step(3);
    chk("short_ir_mode", 32'(mode), 32'(CAM));
    ir_raw = 3'b001; step(4);
    chk("ir_edge4_mode", 32'(mode), 32'(CAM));
    step(1);
    chk("ir_edge5_mode", 32'(mode), 32'(IR));
    chk("ir_left_obst", 32'(drive_cmd), 32'(RIGHT));
    ir_raw = 3'b100; step(5);
    chk("ir_right_obst", 32'(drive_cmd), 32'(LEFT));
    ir_raw = 3'b010; step(5);
    chk("ir_middle_obst", 32'(drive_cmd), 32'(STOP));
    ir_raw = 3'b000; step(5);
    chk("ir_clear_mode", 32'(mode), 32'(CAM));
    chk("ir_clear_cam", 32'(cam_state), 32'(SEARCH));
    chk("ir_clear_drive", 32'(drive_cmd), 32'(LEFT));

    // Steering and speed bands.
    sample(1, 320, 500);   chk("x320_a500", 32'(drive_cmd), 32'(FAST));
    sample(1, 100, 500);   chk("x100", 32'(drive_cmd), 32'(LEFT));
    sample(1, 360, 5000);  chk("x360_edge", 32'(drive_cmd), 32'(SLOW));
    sample(1, 361, 5000);  chk("x361", 32'(drive_cmd), 32'(RIGHT));
    sample(1, 280, 1000);  chk("x280_edge", 32'(drive_cmd), 32'(MEDIUM));
    sample(1, 279, 20000); chk("x279", 32'(drive_cmd), 32'(LEFT));
    sample(1, 320, 999);   chk("a999", 32'(drive_cmd), 32'(FAST));
    sample(1, 320, 4000);  chk("a4000", 32'(drive_cmd), 32'(SLOW));
    sample(0, 100, 500);   step(2);
    chk("hold_on_notfound", 32'(drive_cmd), 32'(SLOW));

    // PAUSE with and without a found sample.
    sample(1, 320, 12000);
    chk("pause_enter_cam", 32'(cam_state), 32'(PAUSE));
    chk("pause_enter_drive", 32'(drive_cmd), 32'(STOP));
    step(3); sample(1, 100, 500); step(5);
    chk("pause_hold_cam", 32'(cam_state), 32'(PAUSE));
    chk("pause_hold_drive", 32'(drive_cmd), 32'(STOP));
    step(1);
    chk("pause_to_follow", 32'(cam_state), 32'(FOLLOW));
    sample(1, 320, 12000);
    step(9);
    chk("pause2_hold", 32'(cam_state), 32'(PAUSE));
    step(1);
    chk("pause_to_search", 32'(cam_state), 32'(SEARCH));
    chk("pause_to_search_drv", 32'(drive_cmd), 32'(LEFT));

    // Lost-target timeout.
    sample(1, 320, 500);
    cam_valid = 1'b1; cam_found = 1'b0;
    step(19);
    chk("lost_19", 32'(cam_state), 32'(FOLLOW));
    step(1);
    chk("lost_20_cam", 32'(cam_state), 32'(SEARCH));
    chk("lost_20_drive", 32'(drive_cmd), 32'(LEFT));
    cam_valid = 1'b0;
    sample(1, 320, 500);
    cam_valid = 1'b1; cam_found = 1'b0;
    step(18);
    cam_found = 1'b1; cam_x = 10'd320; cam_area = 16'd500;
    step(1);
    cam_found = 1'b0;
    step(19);
    chk("lost_rearm_hold", 32'(cam_state), 32'(FOLLOW));
    step(1);
    chk("lost_rearm_expire", 32'(cam_state), 32'(SEARCH));
    cam_valid = 1'b0;

    // IR beats a coincident camera sample.
    sample(1, 320, 500);
    step(1);
    pulses = 0; count_on = 1'b1;
    ir_raw = 3'b001; step(4);
    sample(1, 100, 500);
    chk("ir_wins_mode", 32'(mode), 32'(IR));
    chk("ir_wins_cam", 32'(cam_state), 32'(SEARCH));
    chk("ir_wins_drive", 32'(drive_cmd), 32'(RIGHT));
    ir_raw = 3'b000; step(4);
    chk("ir_release_hold", 32'(mode), 32'(IR));
    step(1);
    chk("ir_release_mode", 32'(mode), 32'(CAM));
    chk("ir_release_drive", 32'(drive_cmd), 32'(LEFT));
    step(1);
    count_on = 1'b0;
    chk("change_pulses", 32'(pulses), 2);

    enable = 1'b0; step(1);
    chk("disable_mode", 32'(mode), 32'(IDLE));
    chk("disable_drive", 32'(drive_cmd), 32'(STOP));
    step(1);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
